sti_serial_receiver: RTL
========================

# sti_serial_receiver

Serial receiver for the STI link. It sits at the far end of the STI serial output, taking the `so_data`/`so_valid` bit stream as `si_data`/`si_valid`. It deserialises each frame of 8/16/24/32 bits, undoes the MSB/LSB ordering, byte-select and fill placement applied by the transmitter, and recovers the original 16-bit parallel word. Recovered words go into a 2-entry output buffer with a valid/ready handshake; malformed frames are flagged.

## Interface
- No parameters; frame widths are fixed at 8/16/24/32 bits.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- si_data  in  1  serial data bit, sampled when si_valid=1.
- si_valid  in  1  high for every bit of a frame; frames are contiguous high runs.
- cfg_length  in  2  0/1/2/3 = 8/16/24/32-bit frame.
- cfg_msb  in  1  1 = first received bit is frame MSB; 0 = first bit is frame bit 0.
- cfg_low  in  1  length 0 only: 1 = byte belongs in po_data[15:8], 0 = po_data[7:0].
- cfg_fill  in  1  lengths 2/3 only: 1 = data in frame upper 16 bits, 0 = lower 16 bits.
- po_ready  in  1  consumer accepts po_data when po_valid & po_ready.
- po_data  out  16  head-of-buffer recovered word.
- po_valid  out  1  buffer non-empty.
- po_err  out  1  one-cycle pulse: frame bit count ≠ expected.
- po_ovf  out  1  one-cycle pulse: good frame dropped, buffer full.
- frame_cnt  out  8  count of frames pushed into buffer; wraps 255→0.

## Operation
- States: IDLE, RECV.
- IDLE: si_valid=1 → RECV.
  - cfg_* latched into shadow registers.
  - Bit counter = 1.
  - First bit stored.
- RECV: si_valid=1 → store bit; counter +1, saturating at 33. Bits beyond the 32nd are not stored.
- RECV: si_valid=0 → end of frame; evaluate at this same edge; return to IDLE.
- Shift register sr[31:0], cleared at frame start:
  - msb=1: sr <= {sr[30:0], bit}.
  - msb=0: sr[count] <= bit.
- Frame word F = sr[N-1:0], where N = 8·(cfg_length+1), from the latched config.
- Extraction:
  - len0: low ? {F[7:0],8'h00} : {8'h00,F[7:0]}.
  - len1: F[15:0].
  - len2: fill ? F[23:8] : F[15:0].
  - len3: fill ? F[31:16] : F[15:0].
- End-of-frame outcomes:
  - count ≠ N: po_err pulse; no push; frame_cnt unchanged.
  - count = N, buffer has room: push; frame_cnt +1.
  - count = N, buffer full and no pop this cycle: drop; po_ovf pulse.
- Buffer: 2-entry FIFO, in order.
  - Pop when po_valid & po_ready.
  - Push and pop in the same cycle are both honoured, including when full.
  - Pop when empty is ignored.
- Config inputs are ignored except at frame start, so changing them mid-frame has no effect.

## Timing
- Reset values: po_data=0, po_valid=0, po_err=0, po_ovf=0, frame_cnt=0; state=IDLE, sr=0, buffer empty.
- Reset mid-frame discards the partial frame and all buffered words.
- Latency: edge Ek samples si_valid=0 ending the frame; po_valid/po_data reflect the word right after Ek (buffer was empty). po_err/po_ovf are high for the cycle after Ek only.
- Minimum inter-frame gap: one cycle of si_valid=0. A bit at Ek+1 starts the next frame.
- Buffered po_data is stable while po_valid=1 and po_ready=0.
- frame_cnt updates at the push edge.

## Test plan
- len1, msb=1, 16 bits of 16'hA5C3 MSB-first, po_ready=1 → po_data=16'hA5C3, po_valid high 1 cycle after last bit, frame_cnt=1.
- len0, msb=0, low=1, 8'h5A LSB-first → po_data=16'h5A00; same with low=0 → 16'h005A.
- len3, msb=1, fill=1, 32'h1234_0000 → 16'h1234. len3 fill=0 with 32'h0000_BEEF → 16'hBEEF. len2 fill=1 with 24'hC0FF_EE → 16'hC0FF.
- len2 frame with only 20 valid bits → po_err one-cycle pulse, po_valid stays 0, frame_cnt unchanged. 40-bit frame → po_err.
- po_ready=0, three good len1 frames 1111/2222/3333 → third gives po_ovf. Then po_ready=1 → 1111, 2222 in order, frame_cnt=2. Also: full buffer with push+pop in same cycle → no ovf.
- reset asserted after 5 bits of a frame → all outputs 0. Next complete len1 frame 16'h0F0F → received correctly.

Source files
------------

// File: rtl/sti_serial_receiver_if.sv
// Bundles the STI serial input, frame config and recovered-word handshake.
// The bench drives through master; the receiver connects as slave.
interface sti_serial_receiver_if;
  logic        si_data;
  logic        si_valid;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic        cfg_low;
  logic        cfg_fill;
  logic        po_ready;
  logic [15:0] po_data;
  logic        po_valid;
  logic        po_err;
  logic        po_ovf;
  logic [7:0]  frame_cnt;

  modport master (
    output si_data, si_valid, cfg_length, cfg_msb, cfg_low, cfg_fill, po_ready,
    input  po_data, po_valid, po_err, po_ovf, frame_cnt
  );

  modport slave (
    input  si_data, si_valid, cfg_length, cfg_msb, cfg_low, cfg_fill, po_ready,
    output po_data, po_valid, po_err, po_ovf, frame_cnt
  );
endinterface

// File: rtl/sti_serial_receiver.sv
// STI serial receiver: deserialises 8/16/24/32-bit frames, recovers the 16-bit
// word and queues it in a 2-entry output buffer with valid/ready handshake.
module sti_serial_receiver (
  input  logic                  clk,
  input  logic                  reset,
  sti_serial_receiver_if.slave  bus
);

  localparam int unsigned SR_W   = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned FC_W   = 8;

  typedef enum logic {IDLE, RECV} state_e;

  state_e              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          len_q, len_d;
  logic                msb_q, msb_d;
  logic                low_q, low_d;
  logic                fill_q, fill_d;
  logic [WORD_W-1:0]   ent0_q, ent0_d;
  logic [WORD_W-1:0]   ent1_q, ent1_d;
  logic [1:0]          occ_q, occ_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
  logic [FC_W-1:0]     fcnt_q, fcnt_d;

  logic [CNT_W-1:0]    exp_n;
  logic [WORD_W-1:0]   word;
  logic                push;
  logic                pop;
  logic [1:0]          occ_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      msb_q   <= 1'b0;
      low_q   <= 1'b0;
      fill_q  <= 1'b0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      occ_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      msb_q   <= msb_d;
      low_q   <= low_d;
      fill_q  <= fill_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Expected bit count and word placement come from the config latched at frame start
  always_comb begin
    exp_n = CNT_W'({len_q, 3'b000}) + CNT_W'(8);
    word  = '0;
    unique case (len_q)
      2'd0:    word = low_q ? {sr_q[7:0], 8'h00} : {8'h00, sr_q[7:0]};
      2'd1:    word = sr_q[15:0];
      2'd2:    word = fill_q ? sr_q[23:8]  : sr_q[15:0];
      default: word = fill_q ? sr_q[31:16] : sr_q[15:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    msb_d   = msb_q;
    low_d   = low_q;
    fill_d  = fill_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    occ_d   = occ_q;
    fcnt_d  = fcnt_q;
    err_d   = 1'b0;
    ovf_d   = 1'b0;
    push    = 1'b0;
    pop     = valid_q & bus.po_ready;
    occ_n   = occ_q;

    unique case (state_q)
      IDLE: begin
        if (bus.si_valid) begin
          state_d = RECV;
          len_d   = bus.cfg_length;
          msb_d   = bus.cfg_msb;
          low_d   = bus.cfg_low;
          fill_d  = bus.cfg_fill;
          cnt_d   = CNT_W'(1);
          sr_d    = {{(SR_W-1){1'b0}}, bus.si_data};
        end
      end
      default: begin
        if (bus.si_valid) begin
          // Bits past the 32nd are counted (to flag the error) but not stored
          if (cnt_q < CNT_W'(SR_W)) begin
            if (msb_q) sr_d = {sr_q[SR_W-2:0], bus.si_data};
            else       sr_d[cnt_q[4:0]] = bus.si_data;
          end
          if (cnt_q != CNT_W'(33)) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = IDLE;
          if (cnt_q == exp_n) push  = 1'b1;
          else                err_d = 1'b1;
        end
      end
    endcase

    // Pop first so a push into a full buffer that is draining this cycle lands
    if (pop) begin
      ent0_d = ent1_q;
      occ_n  = occ_q - 2'd1;
    end
    occ_d = occ_n;
    if (push) begin
      if (occ_n == 2'd0) begin
        ent0_d = word;
        occ_d  = 2'd1;
        fcnt_d = fcnt_q + FC_W'(1);
      end else if (occ_n == 2'd1) begin
        ent1_d = word;
        occ_d  = 2'd2;
        fcnt_d = fcnt_q + FC_W'(1);
      end else begin
        ovf_d  = 1'b1;
      end
    end
    valid_d = (occ_d != 2'd0);
  end

  assign bus.po_data   = ent0_q;
  assign bus.po_valid  = valid_q;
  assign bus.po_err    = err_q;
  assign bus.po_ovf    = ovf_q;
  assign bus.frame_cnt = fcnt_q;

endmodule
